// File: rtl/xm_seq_controller.sv
// xm_seq_controller: multi-cycle instruction sequencer for the X-Makina core.
// Walks each instruction class through fetch, decode, execute, memory-wait and
// write-back states and drives the PC, register-file and memory strobes.
//
// Optional feature macro: XM_CTRL_TIMEOUT_EN (bus-timeout counter, cause 2).
//
// Ports:
//   clk_i, arst_i            clock, synchronous active-high reset
//   memBusy_i                memory not ready (sampled in wait states)
//   intReq_i, intEn_i        interrupt request / enable
//   instOp_i                 decoded instruction class
//   branchRes_i, byteOp_i    branch condition, byte-wide op
//   regAdrA_i, regAdrB_i     decoded register addresses
//   pcWr_o .. byteOp_o       datapath strobes
//   pcSel_o, regWrMode_o     PC source / write-back source
//   regWrAdr_o, regAdrA_o/B  register-file addresses
//   excAck_o, excCause_o     exception entry pulse / latched cause
//   state_o                  current state (debug)
module xm_seq_controller #(
    parameter int unsigned WORD        = 16,
    parameter int unsigned LR          = 5,
    parameter int unsigned PC          = 7,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic       memBusy_i,
    input  logic       intReq_i,
    input  logic       intEn_i,
    input  logic [3:0] instOp_i,
    input  logic       branchRes_i,
    input  logic       byteOp_i,
    input  logic [2:0] regAdrA_i,
    input  logic [2:0] regAdrB_i,
    output logic       pcWr_o,
    output logic       regWr_o,
    output logic       irWr_o,
    output logic       memEn_o,
    output logic       memRW_o,
    output logic       byteOp_o,
    output logic [1:0] pcSel_o,
    output logic [1:0] regWrMode_o,
    output logic [2:0] regWrAdr_o,
    output logic [2:0] regAdrA_o,
    output logic [2:0] regAdrB_o,
    output logic       excAck_o,
    output logic [1:0] excCause_o,
    output logic [4:0] state_o
);

    typedef enum logic [4:0] {
        StReset      = 5'd0,
        StFetch      = 5'd1,
        StFetchWait  = 5'd2,
        StDecode     = 5'd3,
        StCondBranch = 5'd4,
        StLinkBranch = 5'd5,
        StAlu        = 5'd6,
        StImmLoad    = 5'd7,
        StMemIssue   = 5'd8,
        StMemWait    = 5'd9,
        StMemWb      = 5'd10,
        StSwap       = 5'd11,
        StSwap2      = 5'd12,
        StExcEntry   = 5'd13
    } state_e;

    localparam logic [2:0] LrAdr    = 3'(LR);
    localparam logic [1:0] CauseInt = 2'd0;
    localparam logic [1:0] CauseIll = 2'd1;
`ifdef XM_CTRL_TIMEOUT_EN
    localparam logic [1:0] CauseBus = 2'd2;
    localparam int unsigned CntW    = $clog2(MEM_TIMEOUT + 1);
`endif

    state_e     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       store_q, store_d;   // current memory op is a store
    logic       int_take;
    state_e     end_state;          // successor of any completing instruction

    // Datapath width and PC index are passed through the core unused here.
    logic unused_params;
    assign unused_params = ^{WORD, PC, MEM_TIMEOUT};

`ifdef XM_CTRL_TIMEOUT_EN
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tmo_hit;
    // Fires on the busy cycle that brings the count up to MEM_TIMEOUT.
    assign tmo_hit = memBusy_i && (cnt_q == CntW'(MEM_TIMEOUT - 1));
`endif

    assign int_take  = intReq_i && intEn_i;
    assign end_state = int_take ? StExcEntry : StFetch;

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        store_d     = store_q;
        pcWr_o      = 1'b0;
        regWr_o     = 1'b0;
        irWr_o      = 1'b0;
        memEn_o     = 1'b0;
        memRW_o     = 1'b0;
        byteOp_o    = 1'b0;
        pcSel_o     = 2'd0;
        regWrMode_o = 2'b00;
        regWrAdr_o  = regAdrA_i;
        excAck_o    = 1'b0;

        unique case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                memEn_o = 1'b1;
                pcWr_o  = 1'b1;
                state_d = StFetchWait;
            end
            StFetchWait: begin
                if (!memBusy_i) begin
                    irWr_o  = 1'b1;
                    state_d = StDecode;
                end
`ifdef XM_CTRL_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = StExcEntry;
                    cause_d = CauseBus;
                end
`endif
            end
            StDecode: begin
                store_d = (instOp_i == 4'd4) || (instOp_i == 4'd6);
                case (instOp_i)
                    4'd0:                      state_d = StCondBranch;
                    4'd1:                      state_d = StLinkBranch;
                    4'd2:                      state_d = StAlu;
                    4'd3, 4'd4, 4'd5, 4'd6:    state_d = StMemIssue;
                    4'd7:                      state_d = StImmLoad;
                    4'd8:                      state_d = StSwap;
                    default: begin
                        state_d = StExcEntry;
                        cause_d = CauseIll;
                    end
                endcase
            end
            StCondBranch: begin
                pcSel_o = 2'd1;
                pcWr_o  = branchRes_i;
                state_d = end_state;
            end
            StLinkBranch: begin
                pcSel_o     = 2'd1;
                pcWr_o      = 1'b1;
                regWr_o     = 1'b1;
                regWrAdr_o  = LrAdr;
                regWrMode_o = 2'b11;
                state_d     = end_state;
            end
            StAlu: begin
                regWr_o = 1'b1;
                state_d = end_state;
            end
            StImmLoad: begin
                regWr_o     = 1'b1;
                regWrMode_o = 2'b10;
                state_d     = end_state;
            end
            StMemIssue: begin
                memEn_o  = 1'b1;
                memRW_o  = store_q;
                byteOp_o = byteOp_i;
                state_d  = StMemWait;
            end
            StMemWait: begin
                if (!memBusy_i) begin
                    state_d = store_q ? end_state : StMemWb;
                end
`ifdef XM_CTRL_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = StExcEntry;
                    cause_d = CauseBus;
                end
`endif
            end
            StMemWb: begin
                regWr_o     = 1'b1;
                regWrMode_o = 2'b01;
                byteOp_o    = byteOp_i;
                state_d     = end_state;
            end
            StSwap: begin
                regWr_o    = 1'b1;
                regWrAdr_o = regAdrA_i;
                state_d    = StSwap2;
            end
            StSwap2: begin
                regWr_o    = 1'b1;
                regWrAdr_o = regAdrB_i;
                state_d    = end_state;
            end
            StExcEntry: begin
                regWr_o     = 1'b1;
                regWrAdr_o  = LrAdr;
                regWrMode_o = 2'b11;
                pcSel_o     = 2'd2;
                pcWr_o      = 1'b1;
                excAck_o    = 1'b1;
                state_d     = StFetch;
            end
            default: state_d = StReset;
        endcase

        // Interrupt cause is only recorded when an instruction end actually vectors.
        if (state_d == StExcEntry && state_q != StDecode && state_q != StFetchWait &&
            state_q != StMemWait) begin
            cause_d = CauseInt;
        end
        if (state_q == StMemWait && state_d == StExcEntry && !memBusy_i) begin
            cause_d = CauseInt;
        end
    end

`ifdef XM_CTRL_TIMEOUT_EN
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == StFetchWait || state_q == StMemWait) && memBusy_i) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_d != state_q && (state_d == StFetchWait || state_d == StMemWait)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q <= StReset;
            cause_q <= CauseInt;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            store_q <= store_d;
        end
    end

    assign regAdrA_o  = regAdrA_i;
    assign regAdrB_o  = regAdrB_i;
    assign excCause_o = cause_q;
    assign state_o    = state_q;

endmodule
